// File: rtl/pipo_register_8b_if.sv
// Bus bundle for the parallel-in/parallel-out holding register.
// The master drives the word and capture enable; the slave returns the stored word and valid.
interface pipo_register_8b_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] data_in;
  logic             load;
  logic [WIDTH-1:0] data_out;
  logic             valid;

  modport master (
    output data_in,
    output load,
    input  data_out,
    input  valid
  );

  modport slave (
    input  data_in,
    input  load,
    output data_out,
    output valid
  );

endinterface

// File: rtl/pipo_register_8b.sv
// Edge-triggered holding register: samples data_in when load is high at a rising clock edge.
// valid marks that at least one word has been captured since the last reset.
module pipo_register_8b #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                clock,
  input  logic                reset_n,
  pipo_register_8b_if.slave   bus
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  // Stored word; reset forces RESET_VALUE without waiting for a clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
    end else if (bus.load) begin
      data_q <= bus.data_in;
    end
  end

  // Sticky capture flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
    end else if (bus.load) begin
      valid_q <= 1'b1;
    end
  end

  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;

endmodule

// File: tb/tb_pipo_register_8b.sv
// Directed self-checking bench for pipo_register_8b.
module tb_pipo_register_8b;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  pipo_register_8b_if #(.WIDTH(8)) bus ();

  pipo_register_8b #(
    .WIDTH       (8),
    .RESET_VALUE (8'h00)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // One full clock period; returns with clock low, 3 ns after the falling edge.
  task automatic tick();
    #5 clock = 1'b1;
    #2 clock = 1'b0;
    #3;
  endtask

  task automatic test_reset();
    clock       = 1'b0;
    bus.load    = 1'b0;
    bus.data_in = 8'h00;
    reset_n     = 1'b1;
    #3 reset_n  = 1'b0;
    #1;
    checks++;
    if (bus.data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h expected %h", bus.data_out, 8'h00);
    end
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected %b", bus.valid, 1'b0);
    end
    #2 reset_n  = 1'b1;
    bus.data_in = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.data_out !== 8'h00 || bus.valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got data %h valid %b expected data %h valid %b",
                 i, bus.data_out, bus.valid, 8'h00, 1'b0);
      end
    end
  endtask

  task automatic test_basic_load();
    bus.data_in = 8'hAA;
    bus.load    = 1'b1;
    tick();
    checks++;
    if (bus.data_out !== 8'hAA || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_load: got data %h valid %b expected data %h valid %b",
               bus.data_out, bus.valid, 8'hAA, 1'b1);
    end
    bus.load    = 1'b0;
    bus.data_in = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.data_out !== 8'hAA || bus.valid !== 1'b1) begin
        errors++;
        $display("FAIL basic_hold[%0d]: got data %h valid %b expected data %h valid %b",
                 i, bus.data_out, bus.valid, 8'hAA, 1'b1);
      end
    end
  endtask

  task automatic test_glitch();
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    #1;
    bus.data_in = 8'hAA;
    bus.load    = 1'b1;
    #5 bus.load = 1'b0;
    #1;
    checks++;
    if (bus.data_out !== 8'h00 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_pulse: got data %h valid %b expected data %h valid %b",
               bus.data_out, bus.valid, 8'h00, 1'b0);
    end
    tick();
    checks++;
    if (bus.data_out !== 8'h00 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_edge: got data %h valid %b expected data %h valid %b",
               bus.data_out, bus.valid, 8'h00, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec [3];
    vec[0] = 8'h01;
    vec[1] = 8'h80;
    vec[2] = 8'hFF;
    bus.load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data_in = vec[i];
      tick();
      checks++;
      if (bus.data_out !== vec[i] || bus.valid !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got data %h valid %b expected data %h valid %b",
                 i, bus.data_out, bus.valid, vec[i], 1'b1);
      end
    end
    bus.load = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.data_in = 8'hAA;
    bus.load    = 1'b1;
    tick();
    bus.load    = 1'b0;
    checks++;
    if (bus.data_out !== 8'hAA || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL async_preload: got data %h valid %b expected data %h valid %b",
               bus.data_out, bus.valid, 8'hAA, 1'b1);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.data_out !== 8'h00 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL async_assert: got data %h valid %b expected data %h valid %b",
               bus.data_out, bus.valid, 8'h00, 1'b0);
    end
    // Load presented while reset is held must be ignored.
    bus.data_in = 8'h99;
    bus.load    = 1'b1;
    tick();
    checks++;
    if (bus.data_out !== 8'h00 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL async_held: got data %h valid %b expected data %h valid %b",
               bus.data_out, bus.valid, 8'h00, 1'b0);
    end
    reset_n     = 1'b1;
    bus.data_in = 8'h3C;
    tick();
    bus.load    = 1'b0;
    checks++;
    if (bus.data_out !== 8'h3C || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL async_release: got data %h valid %b expected data %h valid %b",
               bus.data_out, bus.valid, 8'h3C, 1'b1);
    end
  endtask

  task automatic test_walking_ones();
    logic [7:0] exp;
    bus.load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp         = 8'(1 << i);
      bus.data_in = exp;
      tick();
      checks++;
      if (bus.data_out !== exp) begin
        errors++;
        $display("FAIL walking_one[%0d]: got %h expected %h", i, bus.data_out, exp);
      end
    end
    bus.load    = 1'b0;
    bus.data_in = 8'h00;
    tick();
    checks++;
    if (bus.data_out !== 8'h80 || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL walking_hold: got data %h valid %b expected data %h valid %b",
               bus.data_out, bus.valid, 8'h80, 1'b1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_load();
    test_glitch();
    test_back_to_back();
    test_async_reset();
    test_walking_ones();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
